// File: rtl/idma_job_sched.sv
// Round-robin job scheduler in front of a shared iDMA chain: accepts one job at a time,
// issues it to the front-end and routes each in-order retirement back to its owner.
module idma_job_sched #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned JOB_W   = 128,
    parameter int unsigned ID_W    = 32,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*JOB_W-1:0]   req_job_i,
    output logic [JOB_W-1:0]           fe_job_o,
    output logic                       fe_valid_o,
    input  logic                       fe_ready_i,
    input  logic [ID_W-1:0]            next_id_i,
    input  logic                       retire_i,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [ID_W-1:0]            done_id_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       busy_o,
    output logic                       error_o
);

    localparam int unsigned RR_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [JOB_W-1:0]   job_q, job_d;
    logic [RR_W-1:0]    owner_q, owner_d;

    logic [RR_W-1:0]    fifo_owner_q [DEPTH];
    logic [ID_W-1:0]    fifo_id_q    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic               error_q, error_d;

    logic               grant_found;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W:0]      cand;
    logic               push;
    logic               pop;

    // Round-robin search: walk offsets from the top so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (RR_W+1)'(i);
            if (cand >= (RR_W+1)'(NUM_REQ)) begin
                cand = cand - (RR_W+1)'(NUM_REQ);
            end
            if (req_valid_i[cand[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            job_q    <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            job_q    <= job_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        job_d       = job_q;
        owner_d     = owner_q;
        req_ready_o = '0;
        fe_valid_o  = 1'b0;
        push        = 1'b0;
        if (clear_i || !rst_ni) begin
            state_d  = IDLE;
            rr_ptr_d = '0;
            job_d    = '0;
            owner_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < CNT_W'(DEPTH) && grant_found) begin
                        req_ready_o[grant_idx] = 1'b1;
                        job_d    = req_job_i[grant_idx*JOB_W +: JOB_W];
                        owner_d  = grant_idx;
                        rr_ptr_d = (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    fe_valid_o = 1'b1;
                    if (fe_ready_i) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outstanding queue storage needs no reset: only entries between rd and wr are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_owner_q[wr_ptr_q] <= owner_q;
            fifo_id_q[wr_ptr_q]    <= next_id_i;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        done_d    = '0;
        done_id_d = '0;
        error_d   = error_q;
        pop       = 1'b0;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            error_d  = 1'b0;
        end else begin
            pop = retire_i && (count_q != '0);
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d                       = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                done_d[fifo_owner_q[rd_ptr_q]] = 1'b1;
                done_id_d                      = fifo_id_q[rd_ptr_q];
            end
            if (retire_i && (count_q == '0)) begin
                error_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= '0;
            done_id_q <= '0;
            error_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            error_q   <= error_d;
        end
    end

    assign fe_job_o      = job_q;
    assign outstanding_o = count_q;
    assign busy_o        = (state_q == ISSUE) || (count_q != '0);
    assign done_o        = done_q;
    assign done_id_o     = done_id_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_idma_job_sched.sv
// Scenario bench for idma_job_sched: expected completions are queued when jobs are
// issued and popped when the scheduler pulses done.
module tb_idma_job_sched;

    localparam int NUM_REQ = 2;
    localparam int JOB_W   = 128;
    localparam int ID_W    = 32;
    localparam int DEPTH   = 4;

    logic                     clk_i;
    logic                     rst_ni;
    logic                     clear_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*JOB_W-1:0] req_job_i;
    logic [JOB_W-1:0]         fe_job_o;
    logic                     fe_valid_o;
    logic                     fe_ready_i;
    logic [ID_W-1:0]          next_id_i;
    logic                     retire_i;
    logic [NUM_REQ-1:0]       done_o;
    logic [ID_W-1:0]          done_id_o;
    logic [2:0]               outstanding_o;
    logic                     busy_o;
    logic                     error_o;

    typedef struct {
        logic [NUM_REQ-1:0] owner;
        logic [ID_W-1:0]    id;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    idma_job_sched #(
        .NUM_REQ(NUM_REQ), .JOB_W(JOB_W), .ID_W(ID_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_job_i(req_job_i),
        .fe_job_o(fe_job_o), .fe_valid_o(fe_valid_o), .fe_ready_i(fe_ready_i),
        .next_id_i(next_id_i), .retire_i(retire_i),
        .done_o(done_o), .done_id_o(done_id_o),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .error_o(error_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        req_valid_i = '0;
        req_job_i   = '0;
        fe_ready_i  = 1'b0;
        next_id_i   = '0;
        retire_i    = 1'b0;
        clear_i     = 1'b0;
    endtask

    task automatic set_job(input int r, input logic [JOB_W-1:0] j);
        req_job_i[r*JOB_W +: JOB_W] = j;
    endtask

    task automatic do_clear();
        tick();
        idle_inputs();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_q.delete();
    endtask

    // Accept + issue of one job from requester r with the front-end ready.
    task automatic issue_job(input int r, input logic [JOB_W-1:0] j, input logic [ID_W-1:0] id);
        tick();
        req_valid_i = NUM_REQ'(1 << r);
        set_job(r, j);
        fe_ready_i  = 1'b1;
        next_id_i   = id;
        retire_i    = 1'b0;
        tick();
        req_valid_i = '0;
        exp_q.push_back('{owner: NUM_REQ'(1 << r), id: id});
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        req_valid_i = 2'b01;
        tick();
        #1;
        total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready_o); end
        total++; if (fe_valid_o !== 1'b0) begin bad++; $display("FAIL reset_fe_valid got=%b want=0", fe_valid_o); end
        total++; if (fe_job_o !== '0) begin bad++; $display("FAIL reset_fe_job got=%h want=0", fe_job_o); end
        total++; if (done_o !== 2'b00 || done_id_o !== '0) begin bad++; $display("FAIL reset_done got=%b/%0d want=00/0", done_o, done_id_o); end
        total++; if (outstanding_o !== 3'd0 || busy_o !== 1'b0 || error_o !== 1'b0) begin bad++; $display("FAIL reset_status got=%0d/%b/%b want=0/0/0", outstanding_o, busy_o, error_o); end
        req_valid_i = '0;
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        tick();
        req_valid_i = 2'b01; set_job(0, 128'hA5); fe_ready_i = 1'b1; next_id_i = 32'd7;
        #1;
        total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", req_ready_o); end
        tick();
        req_valid_i = '0;
        #1;
        total++; if (fe_valid_o !== 1'b1 || fe_job_o !== 128'hA5) begin bad++; $display("FAIL single_issue got=%b/%h want=1/a5", fe_valid_o, fe_job_o); end
        exp_q.push_back('{owner: 2'b01, id: 32'd7});
        tick();
        #1;
        total++; if (outstanding_o !== 3'd1 || busy_o !== 1'b1 || fe_valid_o !== 1'b0) begin bad++; $display("FAIL single_outstanding got=%0d/%b/%b want=1/1/0", outstanding_o, busy_o, fe_valid_o); end
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        #1;
        e = exp_q.pop_front();
        $display("done owner=%b id=%0d", done_o, done_id_o);
        total++; if (done_o !== e.owner || done_id_o !== e.id) begin bad++; $display("FAIL single_done got=%b/%0d want=%b/%0d", done_o, done_id_o, e.owner, e.id); end
        total++; if (outstanding_o !== 3'd0 || busy_o !== 1'b0) begin bad++; $display("FAIL single_idle got=%0d/%b want=0/0", outstanding_o, busy_o); end
        tick();
        #1;
        total++; if (done_o !== 2'b00 || done_id_o !== '0) begin bad++; $display("FAIL single_done_pulse got=%b/%0d want=00/0", done_o, done_id_o); end
    endtask

    task automatic test_round_robin();
        do_clear();
        for (int k = 0; k < 4; k++) begin
            int g;
            logic [JOB_W-1:0] want_job;
            g = k % 2;
            want_job = (g == 0) ? 128'h100 + 128'(k) : 128'h200 + 128'(k);
            tick();
            req_valid_i = 2'b11;
            set_job(0, 128'h100 + 128'(k));
            set_job(1, 128'h200 + 128'(k));
            fe_ready_i = 1'b1;
            next_id_i  = 32'(20 + k);
            retire_i   = (k > 0);
            #1;
            total++; if (req_ready_o !== 2'(1 << g)) begin bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready_o, 2'(1 << g)); end
            tick();
            retire_i = 1'b0;
            #1;
            total++; if (fe_valid_o !== 1'b1 || fe_job_o !== want_job) begin bad++; $display("FAIL rr_issue k=%0d got=%b/%h want=1/%h", k, fe_valid_o, fe_job_o, want_job); end
            if (k > 0) begin
                e = exp_q.pop_front();
                $display("done owner=%b id=%0d", done_o, done_id_o);
                total++; if (done_o !== e.owner || done_id_o !== e.id) begin bad++; $display("FAIL rr_done k=%0d got=%b/%0d want=%b/%0d", k, done_o, done_id_o, e.owner, e.id); end
            end
            exp_q.push_back('{owner: 2'(1 << g), id: 32'(20 + k)});
        end
        tick();
        req_valid_i = '0; retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        #1;
        e = exp_q.pop_front();
        $display("done owner=%b id=%0d", done_o, done_id_o);
        total++; if (done_o !== e.owner || done_id_o !== e.id) begin bad++; $display("FAIL rr_done_last got=%b/%0d want=%b/%0d", done_o, done_id_o, e.owner, e.id); end
        total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL rr_empty got=%0d want=0", outstanding_o); end
    endtask

    task automatic test_backpressure_full();
        do_clear();
        tick();
        req_valid_i = 2'b01; set_job(0, 128'hDEAD_0001); fe_ready_i = 1'b0; next_id_i = 32'd30;
        #1;
        total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL bp_accept got=%b want=01", req_ready_o); end
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            total++; if (fe_valid_o !== 1'b1 || fe_job_o !== 128'hDEAD_0001 || req_ready_o !== 2'b00) begin bad++; $display("FAIL bp_stall c=%0d got=%b/%h/%b want=1/dead0001/00", c, fe_valid_o, fe_job_o, req_ready_o); end
        end
        tick();
        fe_ready_i = 1'b1; req_valid_i = '0;
        exp_q.push_back('{owner: 2'b01, id: 32'd30});
        for (int j = 1; j < 4; j++) begin
            issue_job(0, 128'hDEAD_0001 + 128'(j), 32'(30 + j));
        end
        tick();
        fe_ready_i = 1'b0; req_valid_i = 2'b01; set_job(0, 128'hBEEF);
        #1;
        total++; if (outstanding_o !== 3'd4 || req_ready_o !== 2'b00 || busy_o !== 1'b1) begin bad++; $display("FAIL full_block got=%0d/%b/%b want=4/00/1", outstanding_o, req_ready_o, busy_o); end
        tick();
        retire_i = 1'b1;
        #1;
        total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL full_hold got=%b want=00", req_ready_o); end
        tick();
        retire_i = 1'b0; next_id_i = 32'd40;
        #1;
        e = exp_q.pop_front();
        $display("done owner=%b id=%0d", done_o, done_id_o);
        total++; if (done_o !== e.owner || done_id_o !== e.id) begin bad++; $display("FAIL full_done got=%b/%0d want=%b/%0d", done_o, done_id_o, e.owner, e.id); end
        total++; if (req_ready_o !== 2'b01 || outstanding_o !== 3'd3) begin bad++; $display("FAIL full_reenable got=%b/%0d want=01/3", req_ready_o, outstanding_o); end
        tick();
        req_valid_i = '0; fe_ready_i = 1'b1;
        #1;
        total++; if (fe_valid_o !== 1'b1 || fe_job_o !== 128'hBEEF) begin bad++; $display("FAIL full_issue got=%b/%h want=1/beef", fe_valid_o, fe_job_o); end
        exp_q.push_back('{owner: 2'b01, id: 32'd40});
        tick();
        fe_ready_i = 1'b0;
        #1;
        total++; if (outstanding_o !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d want=4", outstanding_o); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        issue_job(0, 128'h10, 32'd10);
        issue_job(1, 128'h11, 32'd11);
        tick();
        fe_ready_i = 1'b0; req_valid_i = 2'b01; set_job(0, 128'h12); next_id_i = 32'd12;
        #1;
        total++; if (outstanding_o !== 3'd2 || req_ready_o !== 2'b01) begin bad++; $display("FAIL sim_pre got=%0d/%b want=2/01", outstanding_o, req_ready_o); end
        tick();
        req_valid_i = '0; fe_ready_i = 1'b1; retire_i = 1'b1;
        exp_q.push_back('{owner: 2'b01, id: 32'd12});
        tick();
        fe_ready_i = 1'b0; retire_i = 1'b0;
        #1;
        total++; if (outstanding_o !== 3'd2) begin bad++; $display("FAIL sim_count got=%0d want=2", outstanding_o); end
        e = exp_q.pop_front();
        $display("done owner=%b id=%0d", done_o, done_id_o);
        total++; if (done_o !== e.owner || done_id_o !== e.id) begin bad++; $display("FAIL sim_done got=%b/%0d want=%b/%0d", done_o, done_id_o, e.owner, e.id); end
        for (int j = 0; j < 2; j++) begin
            tick();
            retire_i = 1'b1;
            tick();
            retire_i = 1'b0;
            #1;
            e = exp_q.pop_front();
            $display("done owner=%b id=%0d", done_o, done_id_o);
            total++; if (done_o !== e.owner || done_id_o !== e.id) begin bad++; $display("FAIL sim_tail j=%0d got=%b/%0d want=%b/%0d", j, done_o, done_id_o, e.owner, e.id); end
        end
        total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL sim_empty got=%0d want=0", outstanding_o); end
    endtask

    task automatic test_spurious_retire();
        do_clear();
        tick();
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        #1;
        total++; if (error_o !== 1'b1 || done_o !== 2'b00 || done_id_o !== '0) begin bad++; $display("FAIL spur_error got=%b/%b/%0d want=1/00/0", error_o, done_o, done_id_o); end
        tick();
        #1;
        total++; if (error_o !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b want=1", error_o); end
        tick();
        clear_i = 1'b1; req_valid_i = 2'b01;
        #1;
        total++; if (req_ready_o !== 2'b00 || fe_valid_o !== 1'b0) begin bad++; $display("FAIL clear_force got=%b/%b want=00/0", req_ready_o, fe_valid_o); end
        tick();
        clear_i = 1'b0; req_valid_i = '0;
        #1;
        total++; if (error_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL clear_error got=%b/%b want=0/0", error_o, busy_o); end
    endtask

    task automatic test_mid_transfer_abort();
        do_clear();
        for (int j = 0; j < 3; j++) issue_job(j % 2, 128'h70 + 128'(j), 32'(50 + j));
        tick();
        req_valid_i = 2'b10; set_job(1, 128'h77); fe_ready_i = 1'b0;
        tick();
        req_valid_i = '0;
        #1;
        total++; if (fe_valid_o !== 1'b1 || outstanding_o !== 3'd3) begin bad++; $display("FAIL abort_pre got=%b/%0d want=1/3", fe_valid_o, outstanding_o); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        #1;
        total++; if (fe_valid_o !== 1'b0 || outstanding_o !== 3'd0 || busy_o !== 1'b0) begin bad++; $display("FAIL abort_clear got=%b/%0d/%b want=0/0/0", fe_valid_o, outstanding_o, busy_o); end
        exp_q.delete();
        for (int j = 0; j < 3; j++) issue_job(j % 2, 128'h80 + 128'(j), 32'(60 + j));
        tick();
        req_valid_i = 2'b10; set_job(1, 128'h88); fe_ready_i = 1'b0;
        tick();
        req_valid_i = '0;
        #1;
        total++; if (fe_valid_o !== 1'b1 || outstanding_o !== 3'd3) begin bad++; $display("FAIL rst_pre got=%b/%0d want=1/3", fe_valid_o, outstanding_o); end
        rst_ni = 1'b0;
        #1;
        total++; if (fe_valid_o !== 1'b0 || outstanding_o !== 3'd0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_async got=%b/%0d/%b want=0/0/0", fe_valid_o, outstanding_o, busy_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        #1;
        total++; if (fe_valid_o !== 1'b0 || outstanding_o !== 3'd0 || fe_job_o !== '0) begin bad++; $display("FAIL rst_after got=%b/%0d/%h want=0/0/0", fe_valid_o, outstanding_o, fe_job_o); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure_full();
        test_simultaneous();
        test_spurious_retire();
        test_mid_transfer_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
